// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-side and memory-side handshake signals of icache_dm
interface icache_dm_if;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        mem_iREN;
  logic [31:0] mem_iaddr;
  logic        mem_iwait;
  logic [31:0] mem_iload;

  // slave: the cache itself; master: the fetch stage plus memory controller around it
  modport slave (
    input  dp_imemREN, dp_imemaddr, mem_iwait, mem_iload,
    output dp_ihit, dp_imemload, mem_iREN, mem_iaddr
  );

  modport master (
    output dp_imemREN, dp_imemaddr, mem_iwait, mem_iload,
    input  dp_ihit, dp_imemload, mem_iREN, mem_iaddr
  );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped, one-word-per-block instruction cache
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_dm #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        icache_inv,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  icache_dm_if.slave  cif
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, next_state;

  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags [NSETS];
  logic [31:0]      data [NSETS];
  logic [29:0]      miss_addr;

  logic [IDXW-1:0]  idx, fill_idx;
  logic [TAGW-1:0]  tag, fill_tag;
  logic             hit, miss_start, fill_done;
  logic [1:0]       unused_byte_off;

  assign idx             = cif.dp_imemaddr[IDXW+1:2];
  assign tag             = cif.dp_imemaddr[31:IDXW+2];
  assign unused_byte_off = cif.dp_imemaddr[1:0];
  assign fill_idx        = miss_addr[IDXW-1:0];
  assign fill_tag        = miss_addr[29:IDXW];

  assign hit = cif.dp_imemREN & valid[idx] & (tags[idx] == tag)
             & (state == IDLE) & ~icache_inv;
  // invalidate outranks starting a miss
  assign miss_start = (state == IDLE) & cif.dp_imemREN & ~hit & ~icache_inv;
  assign fill_done  = (state == FILL) & ~cif.mem_iwait;

  assign cif.dp_ihit     = hit;
  assign cif.dp_imemload = hit ? data[idx] : '0;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cif.mem_iREN  = 1'b0;
    cif.mem_iaddr = '0;
    case (state)
      IDLE: if (miss_start) next_state = FILL;
      FILL: begin
        cif.mem_iREN  = 1'b1;
        cif.mem_iaddr = {miss_addr, 2'b00};
        if (!cif.mem_iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid     <= '0;
      miss_addr <= '0;
      for (int i = 0; i < NSETS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      if (miss_start) miss_addr <= cif.dp_imemaddr[31:2];
      if (fill_done) begin
        tags[fill_idx]  <= fill_tag;
        data[fill_idx]  <= cif.mem_iload;
        valid[fill_idx] <= 1'b1;
      end
      // placed last so an invalidate on the fill-completion cycle leaves the new line invalid
      if (icache_inv) valid <= '0;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1)         hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
